// File: rtl/flux_sched_pkg.sv
// flux_sched_pkg
// Shared types and constants for the FLUX round-robin scheduler slice:
//   sched_state_e : scheduler state (IDLE, BURST)
//   STATS_W       : width of the per-flux token statistics counters
//   tag_width()   : tag width for a given flux count (never less than 1)
package flux_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  localparam int STATS_W = 16;

  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flux_rr_scheduler_if.sv
// flux_rr_scheduler_if
// Bundles the scheduler's FIFO-side and status signals.
//   in_empty/in_dout/in_read : per-flux input FIFO (first-word-fall-through)
//   out_full/out_write/out_din : shared output FIFO, out_din = {tag, data}
//   grant_valid/grant_tag    : current burst lock status
//   tok_cnt                  : per-flux token counters (FLUX_RR_STATS_EN only)
// master = scheduler side, slave = FIFO/observer side.
interface flux_rr_scheduler_if #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8
);
  localparam int TAG_WIDTH = flux_sched_pkg::tag_width(FLUX);

  logic [FLUX-1:0]                 in_empty;
  logic [FLUX-1:0][DATA_WIDTH-1:0] in_dout;
  logic [FLUX-1:0]                 in_read;
  logic                            out_full;
  logic                            out_write;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din;
  logic                            grant_valid;
  logic [TAG_WIDTH-1:0]            grant_tag;
`ifdef FLUX_RR_STATS_EN
  logic [FLUX-1:0][flux_sched_pkg::STATS_W-1:0] tok_cnt;

  modport master (
    input  in_empty, in_dout, out_full,
    output in_read, out_write, out_din, grant_valid, grant_tag, tok_cnt
  );
  modport slave (
    output in_empty, in_dout, out_full,
    input  in_read, out_write, out_din, grant_valid, grant_tag, tok_cnt
  );
`else
  modport master (
    input  in_empty, in_dout, out_full,
    output in_read, out_write, out_din, grant_valid, grant_tag
  );
  modport slave (
    output in_empty, in_dout, out_full,
    input  in_read, out_write, out_din, grant_valid, grant_tag
  );
`endif

endinterface

// File: rtl/flux_rr_scheduler_rr_pick.sv
// rr_pick
// Combinational rotating priority encoder: returns the first asserted req
// scanning ptr, ptr+1, ... modulo FLUX (FLUX need not be a power of two).
//   req   : per-flux request
//   ptr   : highest-priority flux this cycle
//   valid : any request asserted
//   idx   : winning flux
module rr_pick
  import flux_sched_pkg::*;
#(
  parameter  int FLUX = 2,
  localparam int TW   = tag_width(FLUX)
) (
  input  logic [FLUX-1:0] req,
  input  logic [TW-1:0]   ptr,
  output logic            valid,
  output logic [TW-1:0]   idx
);

  int j;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % FLUX;
      if (req[j]) begin
        valid = 1'b1;
        idx   = TW'(j);
      end
    end
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// flux_rr_scheduler
// Shares one downstream FIFO between FLUX tagged input FIFOs. Grants at most
// one non-empty flux per cycle and forwards one token as {tag, data}. A flux
// keeps the grant for up to QUANTUM consecutive tokens, then priority rotates.
// Ports: clk, rst (synchronous, active-high), bus (flux_rr_scheduler_if.master).
// Optional build macro: FLUX_RR_STATS_EN adds per-flux 16-bit token counters
// on bus.tok_cnt.
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter  int FLUX       = 2,
  parameter  int DATA_WIDTH = 8,
  parameter  int QUANTUM    = 4,
  localparam int TAG_WIDTH  = tag_width(FLUX),
  localparam int CNT_W      = $clog2(QUANTUM + 1)
) (
  input logic                  clk,
  input logic                  rst,
  flux_rr_scheduler_if.master  bus
);

  sched_state_e         state_q, state_d;
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
  logic [TAG_WIDTH-1:0] g_q, g_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 pick_valid;
  logic [TAG_WIDTH-1:0] pick_idx;
  logic [TAG_WIDTH-1:0] sel;
  logic [TAG_WIDTH-1:0] sel_next;
  logic                 sel_ok;
  logic                 xfer;
  logic [FLUX-1:0]      in_read_c;

  rr_pick #(.FLUX(FLUX)) u_pick (
    .req   (~bus.in_empty),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;

    sel    = pick_idx;
    sel_ok = pick_valid;
    if (state_q == BURST) begin
      sel    = g_q;
      sel_ok = !bus.in_empty[g_q];
    end
    // rst gates the strobes so nothing is written while reset is held.
    xfer     = sel_ok && !bus.out_full && !rst;
    sel_next = (sel == TAG_WIDTH'(FLUX - 1)) ? '0 : sel + 1'b1;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (QUANTUM == 1) begin
            ptr_d = sel_next;
          end else begin
            g_d     = sel;
            cnt_d   = CNT_W'(1);
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (!sel_ok) begin
          // Locked flux ran dry: release, costing one bubble cycle.
          ptr_d   = sel_next;
          state_d = IDLE;
        end else if (xfer) begin
          if (int'(cnt_q) + 1 == QUANTUM) begin
            ptr_d   = sel_next;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_read_c = xfer ? (FLUX'(1) << sel) : '0;
  end

  assign bus.in_read     = in_read_c;
  assign bus.out_write   = xfer;
  assign bus.out_din     = {sel, bus.in_dout[sel]};
  assign bus.grant_valid = !rst && (state_q == BURST);
  assign bus.grant_tag   = bus.grant_valid ? g_q : '0;

`ifdef FLUX_RR_STATS_EN
  logic [FLUX-1:0][STATS_W-1:0] tok_q, tok_d;

  always_comb begin
    tok_d = tok_q;
    for (int i = 0; i < FLUX; i++) begin
      if (in_read_c[i]) tok_d[i] = tok_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tok_q <= '0;
    else     tok_q <= tok_d;
  end

  assign bus.tok_cnt = tok_q;
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
module tb_flux_rr_scheduler;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT0: FLUX=2 QUANTUM=4, DUT1: FLUX=3 QUANTUM=1, DUT2: FLUX=3 QUANTUM=4
  flux_rr_scheduler_if #(.FLUX(2), .DATA_WIDTH(8)) if0 ();
  flux_rr_scheduler_if #(.FLUX(3), .DATA_WIDTH(8)) if1 ();
  flux_rr_scheduler_if #(.FLUX(3), .DATA_WIDTH(8)) if2 ();

  flux_rr_scheduler #(.FLUX(2), .DATA_WIDTH(8), .QUANTUM(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  flux_rr_scheduler #(.FLUX(3), .DATA_WIDTH(8), .QUANTUM(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  flux_rr_scheduler #(.FLUX(3), .DATA_WIDTH(8), .QUANTUM(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0]  empty_v [3];
  logic [7:0]  dout_v  [3][3];
  logic        full_v  [3];
  logic [31:0] got_wr  [3];
  logic [31:0] got_rd  [3];
  logic [31:0] got_din [3];
  logic [31:0] got_gv  [3];
  logic [31:0] got_gt  [3];

  assign if0.in_empty = empty_v[0][1:0];
  assign if1.in_empty = empty_v[1];
  assign if2.in_empty = empty_v[2];
  assign if0.in_dout  = {dout_v[0][1], dout_v[0][0]};
  assign if1.in_dout  = {dout_v[1][2], dout_v[1][1], dout_v[1][0]};
  assign if2.in_dout  = {dout_v[2][2], dout_v[2][1], dout_v[2][0]};
  assign if0.out_full = full_v[0];
  assign if1.out_full = full_v[1];
  assign if2.out_full = full_v[2];

  assign got_wr[0]  = 32'(if0.out_write);
  assign got_wr[1]  = 32'(if1.out_write);
  assign got_wr[2]  = 32'(if2.out_write);
  assign got_rd[0]  = 32'(if0.in_read);
  assign got_rd[1]  = 32'(if1.in_read);
  assign got_rd[2]  = 32'(if2.in_read);
  assign got_din[0] = 32'(if0.out_din);
  assign got_din[1] = 32'(if1.out_din);
  assign got_din[2] = 32'(if2.out_din);
  assign got_gv[0]  = 32'(if0.grant_valid);
  assign got_gv[1]  = 32'(if1.grant_valid);
  assign got_gv[2]  = 32'(if2.grant_valid);
  assign got_gt[0]  = 32'(if0.grant_tag);
  assign got_gt[1]  = 32'(if1.grant_tag);
  assign got_gt[2]  = 32'(if2.grant_tag);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Input FIFOs as ring buffers, one per DUT and flux.
  logic [7:0] fm [3][3][256];
  int fh [3][3];
  int fc [3][3];

  // Reference model: who owns the output, how many tokens it has sent in this
  // burst, and which flux is first in line when nobody owns it.
  int m_ptr [3];
  int m_own [3];
  int m_run [3];
  int m_tok [3][3];

  logic [31:0] smp_wr  [3];
  logic [31:0] smp_din [3];

  function automatic int nflux(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int quantum(input int k);
    return (k == 1) ? 1 : 4;
  endfunction

  task automatic push(input int k, input int f, input int n);
    for (int i = 0; i < n; i++) begin
      fm[k][f][(fh[k][f] + fc[k][f]) % 256] = 8'($urandom);
      fc[k][f]++;
    end
  endtask

  // One clock cycle: present FIFO heads, predict, compare, pop, advance.
  task automatic step();
    int src, nf, q, c;
    int e_wr, e_rd, e_din, e_gv, e_gt;
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < 3; f++) begin
        empty_v[k][f] = (f >= nflux(k)) || (fc[k][f] == 0);
        dout_v[k][f]  = (fc[k][f] > 0) ? fm[k][f][fh[k][f]] : 8'h00;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      nf   = nflux(k);
      q    = quantum(k);
      src  = -1;
      e_gv = (!rst && m_own[k] >= 0) ? 1 : 0;
      e_gt = (e_gv != 0) ? m_own[k] : 0;
      e_wr = 0;
      e_rd = 0;
      e_din = 0;
      if (rst) begin
        m_ptr[k] = 0;
        m_own[k] = -1;
        m_run[k] = 0;
        for (int f = 0; f < 3; f++) m_tok[k][f] = 0;
      end else if (m_own[k] >= 0) begin
        if (fc[k][m_own[k]] == 0) begin
          m_ptr[k] = (m_own[k] + 1) % nf;
          m_own[k] = -1;
        end else if (!full_v[k]) begin
          src = m_own[k];
        end
      end else if (!full_v[k]) begin
        for (int i = 0; i < nf; i++) begin
          c = (m_ptr[k] + i) % nf;
          if (src < 0 && fc[k][c] > 0) src = c;
        end
      end
      if (src >= 0) begin
        e_wr  = 1;
        e_rd  = 1 << src;
        e_din = (src << 8) | int'(fm[k][src][fh[k][src]]);
        fh[k][src] = (fh[k][src] + 1) % 256;
        fc[k][src]--;
        m_tok[k][src] = (m_tok[k][src] + 1) % 65536;
        if (m_own[k] < 0) begin
          if (q == 1) m_ptr[k] = (src + 1) % nf;
          else begin
            m_own[k] = src;
            m_run[k] = 1;
          end
        end else begin
          m_run[k]++;
          if (m_run[k] == q) begin
            m_ptr[k] = (src + 1) % nf;
            m_own[k] = -1;
          end
        end
      end
      chk($sformatf("dut%0d_out_write", k), got_wr[k], 32'(e_wr));
      chk($sformatf("dut%0d_in_read", k), got_rd[k], 32'(e_rd));
      chk($sformatf("dut%0d_grant_valid", k), got_gv[k], 32'(e_gv));
      chk($sformatf("dut%0d_grant_tag", k), got_gt[k], 32'(e_gt));
      if (e_wr != 0) chk($sformatf("dut%0d_out_din", k), got_din[k], 32'(e_din));
      smp_wr[k]  = got_wr[k];
      smp_din[k] = got_din[k];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int seq0 [16] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      full_v[k] = 1'b0;
      m_ptr[k] = 0;
      m_own[k] = -1;
      m_run[k] = 0;
      for (int f = 0; f < 3; f++) begin
        fh[k][f] = 0;
        fc[k][f] = 0;
        m_tok[k][f] = 0;
      end
    end

    step();
    step();
    rst = 1'b0;

    // FLUX=2 QUANTUM=4: alternating bursts of four with no bubble.
    push(0, 0, 8);
    push(0, 1, 8);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("q4_seq_write", smp_wr[0], 32'd1);
      chk("q4_seq_tag", smp_din[0] >> 8, 32'(seq0[i]));
    end

    // FLUX=3 QUANTUM=1: strict rotation, then a lone flux 2.
    push(1, 0, 6);
    push(1, 1, 6);
    push(1, 2, 6);
    for (int i = 0; i < 18; i++) begin
      step();
      chk("q1_rot_tag", smp_din[1] >> 8, 32'(i % 3));
    end
    push(1, 2, 5);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("q1_only2_write", smp_wr[1], 32'd1);
      chk("q1_only2_tag", smp_din[1] >> 8, 32'd2);
    end

    // FLUX=3 QUANTUM=4: short burst on flux 1, bubble, wrap to flux 0.
    push(2, 1, 2);
    step();
    step();
    step();
    chk("release_bubble", smp_wr[2], 32'd0);
    push(2, 0, 4);
    step();
    chk("wrap_to_flux0", smp_din[2] >> 8, 32'd0);
    for (int i = 0; i < 3; i++) step();

    // Stall mid-burst at cnt=2 on flux 2.
    push(2, 2, 4);
    step();
    step();
    full_v[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_write", smp_wr[2], 32'd0);
      chk("stall_grant_tag", got_gt[2], 32'd2);
    end
    full_v[2] = 1'b0;
    step();
    step();
    step();
    chk("stall_burst_end", got_gv[2], 32'd0);

    // Reset during a burst at cnt=3.
    push(2, 1, 8);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    chk("rst_no_write", smp_wr[2], 32'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic with backpressure and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        for (int f = 0; f < nflux(k); f++) begin
          if ($urandom_range(0, 3) == 0 && fc[k][f] < 200) push(k, f, 1);
        end
        full_v[k] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) full_v[k] = 1'b0;

`ifdef FLUX_RR_STATS_EN
    for (int f = 0; f < 3; f++) chk("tok_cnt_random", 32'(if2.tok_cnt[f]), 32'(m_tok[2][f]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      fh[2][f] = 0;
      fc[2][f] = 0;
    end
    for (int n = 0; n < 70000; n++) begin
      if (fc[2][0] < 2) push(2, 0, 2);
      step();
    end
    chk("tok_cnt_wrap", 32'(if2.tok_cnt[0]), 32'd4464);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flux_rr_scheduler.md
# flux_rr_scheduler

Round-robin scheduler that shares one downstream actor input FIFO between FLUX tagged input fluxes in the multi-dataflow HEVC datapath. Each cycle it grants at most one non-empty input FIFO and moves one token into the output FIFO as {tag, data}. A granted flux keeps the grant for a burst of up to QUANTUM consecutive tokens, then priority rotates. This replaces fixed lowest-index priority and bounds starvation.

## Interface
- FLUX, 2: number of input fluxes (≥2).
- DATA_WIDTH, 8: token payload width.
- QUANTUM, 4: maximum consecutive tokens per grant (≥1).
- TAG_WIDTH, $clog2(FLUX): tag width (derived, not overridden).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_empty  in  FLUX  per-flux FIFO empty (first-word-fall-through FIFOs).
- in_dout  in  FLUX×DATA_WIDTH  per-flux FIFO head data.
- in_read  out  FLUX  per-flux read strobe, one-hot or zero.
- out_full  in  1  output FIFO full.
- out_write  out  1  output FIFO write strobe.
- out_din  out  TAG_WIDTH+DATA_WIDTH  {tag, data}; tag in MSBs.
- grant_valid  out  1  high while in BURST.
- grant_tag  out  TAG_WIDTH  currently locked flux; 0 in IDLE.
- tok_cnt  out  FLUX×16  per-flux transferred-token counters (only with FLUX_RR_STATS_EN).

## Operation
- Registers: state {IDLE, BURST}, ptr (TAG_WIDTH, next-priority flux), g (TAG_WIDTH, locked flux), cnt ($clog2(QUANTUM+1) bits).
- Transfer condition: the selected flux s is non-empty and out_full=0. On transfer, in the same cycle: in_read[s]=1, out_write=1, out_din={s, in_dout[s]}. Otherwise in_read=0, out_write=0, out_din=don't-care.
- IDLE: s is the first non-empty flux scanning ptr, ptr+1, … mod FLUX. This scan is combinational and lives in rr_pick.
  - No non-empty flux, or out_full=1: no transfer; stay IDLE.
  - Transfer with QUANTUM=1: ptr←s+1 mod FLUX; stay IDLE.
  - Transfer with QUANTUM>1: g←s, cnt←1; go to BURST.
- BURST: s=g.
  - in_empty[g]=1: no transfer; ptr←g+1; go to IDLE. This costs one bubble cycle.
  - out_full=1 and in_empty[g]=0: stall. Hold g and cnt; stay BURST indefinitely.
  - Transfer with cnt+1=QUANTUM: ptr←g+1; go to IDLE.
  - Transfer otherwise: cnt←cnt+1.
- Modulo FLUX wrap is explicit, because FLUX need not be a power of two.
- in_read is never asserted for an empty FIFO. out_write is never asserted while out_full=1.

## Timing
- Zero-latency combinational path: in_empty/out_full to in_read/out_write/out_din, within the same cycle.
- Throughput is 1 token/cycle while the granted flux stays non-empty.
- There is one bubble cycle on burst release caused by in_empty[g].
- A QUANTUM-limited release incurs no bubble.
- Reset values (held during rst, including combinational outputs): state=IDLE, ptr=0, g=0, cnt=0, in_read=0, out_write=0, grant_valid=0, grant_tag=0, tok_cnt=0.
- Reset mid-burst aborts the burst with no partial write. On the first cycle after reset, flux 0 has highest priority.

## Configuration
- FLUX_RR_STATS_EN defined: tok_cnt port present. tok_cnt[i] increments on each transfer from flux i and wraps 0xFFFF→0.
- FLUX_RR_STATS_EN undefined: tok_cnt port and counters absent. Behaviour is otherwise identical.

## Structure
- Package flux_sched_pkg holds:
  - the state enum (IDLE, BURST);
  - the tag-width helper function;
  - the stats counter width constant (16).
- Sub-module rr_pick (FLUX parameter): inputs req[FLUX] and ptr; outputs valid and idx. It is a purely combinational rotating priority encoder.

## Test plan
- FLUX=2, QUANTUM=4, both FIFOs hold 8 tokens, out never full -> out_din tags 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 on 16 consecutive cycles with no bubble.
- FLUX=3, QUANTUM=1, all non-empty -> tags 0,1,2,0,1,2…; with only flux 2 non-empty -> every write carries tag 2.
- BURST on flux 1 with 2 tokens, QUANTUM=4 -> 2 writes, then 1 idle cycle, then next write from flux 0 (ptr=2 wraps to 0 if flux 2 empty).
- out_full asserted for 5 cycles mid-burst at cnt=2 -> out_write=0 and in_read=0 for those 5 cycles, g unchanged; burst resumes and ends after 2 more tokens.
- rst asserted in BURST at cnt=3 -> next cycle state IDLE, ptr=0, grant_valid=0, no write during rst.
- With FLUX_RR_STATS_EN, 70000 tokens from flux 0 -> tok_cnt[0]=70000 mod 65536=4464.
